instruction_loader: RTL
=======================

Name: instruction_loader

Overview:
- Byte-serial program loader that assembles 32-bit instruction words and writes them into instruction memory.
- It is the writer side of the instruction path; the decoder fetches and consumes the words it writes.
- Every completed word has its opcode checked against the decoder's supported opcode set before it is written.
- A load session ends on an end-of-program marker word, or on an error.

Parameters:
- ADDR_WIDTH, 10, instruction memory address width; capacity is 2^ADDR_WIDTH words.
- END_MARKER, 32'hFFFFFFFF, word that terminates a session; it is never written to memory.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session.
- byteIn  input  8  program byte.
- byteValid  input  1  byteIn is valid this cycle.
- byteReady  output  1  loader accepts a byte this cycle.
- instrAddr  output  ADDR_WIDTH  instruction memory write address.
- instrData  output  32  instruction word to write.
- instrWriteEnable  output  1  one-cycle write strobe.
- loading  output  1  a session is in progress.
- done  output  1  session ended cleanly; held until the next start.
- errorCode  output  2  00 none, 01 bad opcode, 10 overflow; held until the next start.
- wordCount  output  ADDR_WIDTH+1  number of words written in the current session.

Behaviour:
- All outputs are registered.
- Reset:
  - Synchronous, active-high; on reset every output is 0 and the state is IDLE.
  - Reset mid-session discards any partial word and performs no write.
- States: IDLE, RECEIVE, WRITE, DONE, ERROR.
- IDLE:
  - byteReady=0, loading=0.
  - start=1 → RECEIVE; clears instrAddr, wordCount, byte index, done, errorCode.
- RECEIVE:
  - byteReady=1, loading=1.
  - A byte is accepted when byteValid && byteReady. Bytes are big-endian: the first byte goes to bits 31:24, the fourth to bits 7:0.
  - byteValid while byteReady=0 is ignored; the byte is not consumed and the sender must hold it.
  - When the 4th byte is accepted → WRITE.
- WRITE (exactly one cycle, byteReady=0), checked in priority order:
  1. Word == END_MARKER → DONE; no write strobe.
  2. opcode = word[31:28] is not in {0,1,2,3,5,6,7,8,9,10,11,13} → ERROR, errorCode=01; no write.
  3. wordCount == 2^ADDR_WIDTH → ERROR, errorCode=10; no write.
  4. Otherwise: instrWriteEnable=1 for this cycle with instrAddr/instrData stable; instrAddr increments (wrapping to 0 after the maximum address, which is harmless because of the overflow check); wordCount increments; → RECEIVE.
- Timing: if the 4th byte is accepted on the edge ending cycle N, the write strobe is in cycle N+1 and byteReady returns to 1 in cycle N+2. Sustained throughput is 4 bytes per 5 cycles.
- DONE: done=1, loading=0, byteReady=0. start → new session (same clearing as from IDLE).
- ERROR: errorCode held, loading=0, byteReady=0. start → new session.
- start while RECEIVE or WRITE is ignored.
- instrData holds the last assembled word after a write. instrAddr holds the next free address.

Test Plan:
- Reset, then start; bytes 00 00 00 05, then FF FF FF FF. Required: one strobe with addr 0, data 32'h00000005; done=1; wordCount=1; errorCode=00.
- Three words 32'h10000001, 32'h50000003, 32'hB0000000, then the end marker. Required: strobes at addrs 0,1,2 with matching data; each strobe exactly one cycle after its 4th byte is accepted; wordCount=3.
- Word 32'h4ABCDEF0 (opcode 4). Required: no strobe; errorCode=01; byteReady=0. A following start clears errorCode and a good word is written at addr 0.
- ADDR_WIDTH=2: five valid words. Required: four strobes at addrs 0–3; the fifth word gives errorCode=10 with no strobe; wordCount=4.
- byteValid toggled randomly with gaps, and bytes presented during WRITE. Required: no byte lost or duplicated; words match the accepted byte order.
- Reset asserted after 2 bytes of a word, then start, then a full word. Required: no strobe from the partial word; the new word is written at addr 0 with correct data.

Source files
------------

// File: rtl/instruction_loader.sv
// Byte-serial program loader: assembles big-endian 32-bit words, screens each
// opcode against the decoder's supported set, and writes accepted words to instruction memory.
module instruction_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] END_MARKER = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byteIn,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic [ADDR_WIDTH-1:0] instrAddr,
  output logic [31:0]           instrData,
  output logic                  instrWriteEnable,
  output logic                  loading,
  output logic                  done,
  output logic [1:0]            errorCode,
  output logic [ADDR_WIDTH:0]   wordCount
);

  typedef enum logic [2:0] {IDLE, RECEIVE, WRITE, DONE, ERROR} state_t;
  typedef enum logic [1:0] {V_WRITE, V_END, V_BADOP, V_OVF} verdict_t;

  localparam logic [1:0]            ERR_NONE   = 2'b00;
  localparam logic [1:0]            ERR_OPCODE = 2'b01;
  localparam logic [1:0]            ERR_OVF    = 2'b10;
  localparam logic [ADDR_WIDTH:0]   CAPACITY   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t      state;
  verdict_t    verdict;
  verdict_t    verdict_next;
  logic [1:0]  byte_idx;
  logic [23:0] shift_q;
  logic [31:0] full_word;

  // Opcodes 4, 12, 14 and 15 have no decoder implementation.
  function automatic logic opcode_ok(input logic [3:0] op);
    case (op)
      4'd4, 4'd12, 4'd14, 4'd15: opcode_ok = 1'b0;
      default:                   opcode_ok = 1'b1;
    endcase
  endfunction

  // The word completed by the byte arriving this cycle, and what WRITE will do with it.
  always_comb begin
    full_word    = {shift_q, byteIn};
    verdict_next = V_WRITE;
    if (full_word == END_MARKER)          verdict_next = V_END;
    else if (!opcode_ok(full_word[31:28])) verdict_next = V_BADOP;
    else if (wordCount == CAPACITY)        verdict_next = V_OVF;
  end

  // NOTE: all state and outputs are registered with non-blocking assignments so every
  // branch below reads the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      verdict          <= V_WRITE;
      byte_idx         <= 2'd0;
      shift_q          <= 24'd0;
      byteReady        <= 1'b0;
      instrAddr        <= '0;
      instrData        <= 32'd0;
      instrWriteEnable <= 1'b0;
      loading          <= 1'b0;
      done             <= 1'b0;
      errorCode        <= ERR_NONE;
      wordCount        <= '0;
    end else begin
      instrWriteEnable <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state     <= RECEIVE;
            byteReady <= 1'b1;
            loading   <= 1'b1;
            instrAddr <= '0;
            wordCount <= '0;
            byte_idx  <= 2'd0;
            done      <= 1'b0;
            errorCode <= ERR_NONE;
          end
        end

        RECEIVE: begin
          if (byteValid && byteReady) begin
            shift_q  <= full_word[23:0];
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Strobe is decided here so it is registered for exactly the WRITE cycle.
              state            <= WRITE;
              byteReady        <= 1'b0;
              verdict          <= verdict_next;
              instrWriteEnable <= (verdict_next == V_WRITE);
              if (verdict_next == V_WRITE) instrData <= full_word;
            end
          end
        end

        WRITE: begin
          case (verdict)
            V_END: begin
              state   <= DONE;
              done    <= 1'b1;
              loading <= 1'b0;
            end
            V_BADOP: begin
              state     <= ERROR;
              errorCode <= ERR_OPCODE;
              loading   <= 1'b0;
            end
            V_OVF: begin
              state     <= ERROR;
              errorCode <= ERR_OVF;
              loading   <= 1'b0;
            end
            default: begin
              state     <= RECEIVE;
              byteReady <= 1'b1;
              instrAddr <= instrAddr + ADDR_ONE;
              wordCount <= wordCount + COUNT_ONE;
            end
          endcase
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
